// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for ram_arbiter; FSM states and the default-size command record
package ram_arb_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int WIDTH_DEF = 8;
  typedef enum logic {IDLE, RD_CAPTURE} state_e;
  typedef struct packed {
    logic                 wr;
    logic [DEPTH_DEF-1:0] addr;
    logic [WIDTH_DEF-1:0] data;
  } cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant from req when grant_en, round-robin pointer (fixed lowest-index priority under RAM_ARB_FIXED_PRIO_EN); ports clk, reset_n, req, grant_en, grant
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         grant_en,
  output logic [N-1:0] grant
);
`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    for (int i = N - 1; i >= 0; i--)
      if (grant_en && req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
  end
`else
  localparam int PW = $clog2(N);
  logic [PW-1:0] ptr_q, ptr_d;
  always_comb begin
    int j;
    grant = '0;
    ptr_d = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      j = j >= N ? j - N : j;
      if (grant_en && req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        ptr_d    = PW'(j >= N - 1 ? 0 : j + 1);
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one sync single-port RAM among NUM_REQ valid/ready requesters; ports clk, reset_n, req_*, rsp_*, ram_*; RAM_ARB_FIXED_PRIO_EN selects fixed priority
import ram_arb_pkg::*;
module ram_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_wr,
  input  logic [NUM_REQ-1:0][DEPTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [NUM_REQ-1:0][WIDTH-1:0]   rsp_data,
  output logic                            ram_enable,
  output logic                            ram_wr_en,
  output logic [DEPTH-1:0]                ram_address,
  output logic [WIDTH-1:0]                ram_data_in,
  input  logic [WIDTH-1:0]                ram_data_out
);
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] owner_q, owner_d, rsp_valid_q, rsp_valid_d, eligible, grant;
  logic [NUM_REQ-1:0][WIDTH-1:0] rsp_data_q, rsp_data_d;
  assign eligible = req_valid & (req_wr | ~rsp_valid_q | rsp_ready);
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (eligible),
    .grant_en (reset_n && state_q == IDLE),
    .grant    (grant)
  );
  assign req_ready  = grant;
  assign ram_enable = |grant;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  always_comb begin
    ram_wr_en   = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        ram_wr_en   = req_wr[i];
        ram_address = req_addr[i];
        ram_data_in = req_data[i];
      end
    state_d     = state_q == IDLE && |grant && !ram_wr_en ? RD_CAPTURE : IDLE;
    owner_d     = state_q == IDLE ? grant : owner_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (state_q == RD_CAPTURE && owner_q[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = ram_data_out;
      end
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a behavioural sync RAM
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] req_valid, req_ready, req_wr, rsp_valid, rsp_ready;
  logic [1:0][3:0] req_addr;
  logic [1:0][7:0] req_data, rsp_data;
  logic ram_enable, ram_wr_en;
  logic [3:0] ram_address;
  logic [7:0] ram_data_in, ram_data_out;
  logic [7:0] mem [16];
  int checks = 0;
  int errors = 0;
  ram_arbiter #(.NUM_REQ(2), .DEPTH(4), .WIDTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .ram_enable   (ram_enable),
    .ram_wr_en    (ram_wr_en),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (ram_enable) begin
      if (ram_wr_en) mem[ram_address] <= ram_data_in;
      else ram_data_out <= mem[ram_address];
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [3:0] a0, input logic [7:0] d0,
                       input logic [3:0] a1, input logic [7:0] d1);
    req_valid   = v;
    req_wr      = w;
    req_addr[0] = a0;
    req_data[0] = d0;
    req_addr[1] = a1;
    req_data[1] = d1;
    #1;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    ram_data_out = 8'h00;
    reset_n = 1'b0;
    rsp_ready = 2'b00;
    drive(2'b00, 2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    cyc();
    cyc();
    reset_n = 1'b1;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_ram_enable", 32'(ram_enable), 32'h0);
    chk("reset_ram_outs", {ram_wr_en, ram_address, ram_data_in}, 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data", 32'(rsp_data), 32'h0);
    // write then read
    drive(2'b01, 2'b01, 4'd3, 8'hA5, 4'd0, 8'h00);
    chk("wr_ready", 32'(req_ready), 32'h1);
    chk("wr_ram", {ram_enable, ram_wr_en, ram_address, ram_data_in}, {1'b1, 1'b1, 4'd3, 8'hA5});
    cyc();
    drive(2'b01, 2'b00, 4'd3, 8'h00, 4'd0, 8'h00);
    chk("rd_ready", 32'(req_ready), 32'h1);
    chk("rd_ram", {ram_enable, ram_wr_en, ram_address}, {1'b1, 1'b0, 4'd3});
    cyc();
    drive(2'b00, 2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    chk("cap_no_grant", {req_ready, ram_enable}, 32'h0);
    chk("cap_rsp_valid", 32'(rsp_valid), 32'h0);
    cyc();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rsp_data0", 32'(rsp_data[0]), 32'hA5);
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
    chk("rsp0_consumed", 32'(rsp_valid), 32'h0);
    // req1 writes addr 5, pointer then favours req0
    drive(2'b10, 2'b10, 4'd0, 8'h00, 4'd5, 8'h3C);
    chk("wr1_ready", 32'(req_ready), 32'h2);
    cyc();
    // contention
    drive(2'b11, 2'b11, 4'd1, 8'h11, 4'd2, 8'h22);
`ifdef RAM_ARB_FIXED_PRIO_EN
    chk("cont_0", 32'(req_ready), 32'h1); cyc();
    chk("cont_1", 32'(req_ready), 32'h1); cyc();
    chk("cont_2", 32'(req_ready), 32'h1); cyc();
    chk("cont_3", 32'(req_ready), 32'h1); cyc();
`else
    chk("cont_0", 32'(req_ready), 32'h1); cyc();
    chk("cont_1", 32'(req_ready), 32'h2); cyc();
    chk("cont_2", 32'(req_ready), 32'h1); cyc();
    chk("cont_3", 32'(req_ready), 32'h2); cyc();
`endif
    // back-pressure: req1 reads addr 5 and leaves the response unconsumed
    drive(2'b10, 2'b00, 4'd0, 8'h00, 4'd5, 8'h00);
    chk("bp_rd1_ready", 32'(req_ready), 32'h2);
    cyc();
    drive(2'b10, 2'b00, 4'd0, 8'h00, 4'd3, 8'h00);
    chk("bp_cap_ready", 32'(req_ready), 32'h0);
    cyc();
    chk("bp_blocked_a", 32'(req_ready), 32'h0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("bp_rsp_data1_a", 32'(rsp_data[1]), 32'h3C);
    cyc();
    chk("bp_blocked_b", {req_ready, ram_enable}, 32'h0);
    chk("bp_rsp_data1_b", 32'(rsp_data[1]), 32'h3C);
    rsp_ready = 2'b10;
    #1;
    chk("bp_released", 32'(req_ready), 32'h2);
    cyc();
    rsp_ready = 2'b00;
    drive(2'b00, 2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    chk("bp_cleared", 32'(rsp_valid), 32'h0);
    chk("bp_rsp_data1_hold", 32'(rsp_data[1]), 32'h3C);
    cyc();
    chk("bp_rsp2_valid", 32'(rsp_valid), 32'h2);
    chk("bp_rsp2_data1", 32'(rsp_data[1]), 32'hA5);
    rsp_ready = 2'b10;
    cyc();
    rsp_ready = 2'b00;
    // write from req1 arriving during req0 RD_CAPTURE
    drive(2'b01, 2'b00, 4'd5, 8'h00, 4'd0, 8'h00);
    chk("wdc_rd0_ready", 32'(req_ready), 32'h1);
    cyc();
    drive(2'b10, 2'b10, 4'd0, 8'h00, 4'd7, 8'h77);
    chk("wdc_cap_ready", 32'(req_ready), 32'h0);
    cyc();
    chk("wdc_wr1_ready", 32'(req_ready), 32'h2);
    chk("wdc_wr1_ram", {ram_enable, ram_wr_en, ram_address, ram_data_in}, {1'b1, 1'b1, 4'd7, 8'h77});
    chk("wdc_rsp0", {rsp_valid, rsp_data[0]}, {2'b01, 8'h3C});
    cyc();
    drive(2'b00, 2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
    // reset in RD_CAPTURE; req0 granted last so the live pointer favours req1
    drive(2'b01, 2'b00, 4'd3, 8'h00, 4'd0, 8'h00);
    chk("rst_rd0_ready", 32'(req_ready), 32'h1);
    cyc();
    drive(2'b00, 2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    reset_n = 1'b0;
    #1;
    chk("rst_during_outs", {req_ready, ram_enable}, 32'h0);
    cyc();
    reset_n = 1'b1;
    #1;
    chk("rst_after_rsp", {rsp_valid, rsp_data}, 32'h0);
    chk("rst_after_ram", {req_ready, ram_enable, ram_wr_en, ram_address, ram_data_in}, 32'h0);
    drive(2'b11, 2'b11, 4'd1, 8'h11, 4'd2, 8'h22);
    chk("rst_next_grant", 32'(req_ready), 32'h1);
    cyc();
    drive(2'b00, 2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
    // address wrap: addr 15 and addr 0 hold distinct data
    drive(2'b01, 2'b01, 4'd0, 8'h0A, 4'd0, 8'h00);
    cyc();
    drive(2'b01, 2'b01, 4'd15, 8'hF0, 4'd0, 8'h00);
    chk("wrap_wr_addr", 32'(ram_address), 32'hF);
    cyc();
    drive(2'b01, 2'b00, 4'd15, 8'h00, 4'd0, 8'h00);
    chk("wrap_rd_addr", {ram_enable, ram_wr_en, ram_address}, {1'b1, 1'b0, 4'd15});
    cyc();
    drive(2'b00, 2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    cyc();
    chk("wrap_rsp15", {rsp_valid, rsp_data[0]}, {2'b01, 8'hF0});
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
    drive(2'b01, 2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    cyc();
    drive(2'b00, 2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    cyc();
    chk("wrap_rsp0", {rsp_valid, rsp_data[0]}, {2'b01, 8'h0A});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequencer and arbiter that shares one single-port synchronous `RAM` instance between `NUM_REQ` requesters. Each requester issues read/write commands over a valid/ready handshake. The block grants one command per issue cycle, drives the RAM control/address/data pins, and captures read data into per-requester response registers with back-pressure. It sits directly in front of the RAM; the RAM itself stays a separate instance.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 2..8
- `DEPTH`, 4: RAM address width in bits (2**DEPTH words)
- `WIDTH`, 8: data word width
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  [NUM_REQ-1:0]  command valid per requester
- `req_ready`  out  [NUM_REQ-1:0]  command accepted this cycle (one-hot or zero)
- `req_wr`  in  [NUM_REQ-1:0]  1 = write, 0 = read
- `req_addr`  in  [NUM_REQ-1:0][DEPTH-1:0]  command address
- `req_data`  in  [NUM_REQ-1:0][WIDTH-1:0]  write data
- `rsp_valid`  out  [NUM_REQ-1:0]  read data pending per requester
- `rsp_ready`  in  [NUM_REQ-1:0]  requester consumes read data
- `rsp_data`  out  [NUM_REQ-1:0][WIDTH-1:0]  read data per requester
- `ram_enable`, `ram_wr_en`  out  1  to RAM `enable` / `wr_en`
- `ram_address`  out  DEPTH  to RAM `address`
- `ram_data_in`  out  WIDTH  to RAM `data_in`
- `ram_data_out`  in  WIDTH  from RAM `data_out` (registered, valid 1 cycle after read issue)

## Operation
- FSM states: `IDLE`, `RD_CAPTURE`.
- **IDLE:** compute the eligible set.
  - Requester i is eligible if `req_valid[i]` is high, and, for reads only, `rsp_valid[i]` is low or `rsp_ready[i]` is high in the same cycle.
  - Grant the winner: `req_ready[winner]`=1, `ram_enable`=1, `ram_wr_en`=`req_wr[winner]`, address and data muxed from the winner.
  - A write stays in `IDLE`, so back-to-back writes are allowed.
  - A read records the owner and moves to `RD_CAPTURE`.
- **RD_CAPTURE:** no grant this cycle, all `req_ready`=0, `ram_enable`=0.
  - Load `rsp_data[owner]` from `ram_data_out` and set `rsp_valid[owner]`; return to `IDLE`.
- `rsp_valid[i]` clears on `rsp_valid[i] & rsp_ready[i]`. A set and a clear of the same requester in the same cycle resolves as set with the new data.
- Arbitration is round-robin. The most recently granted requester has the lowest priority next time. The pointer advances only on a grant.
- Writes never produce a response.
- Unselected RAM outputs are driven to 0 whenever `ram_enable`=0.

## Timing
- Reset (`reset_n`=0 at a rising edge):
  - state `IDLE`, RR pointer makes requester 0 highest priority
  - all `rsp_valid`=0, `rsp_data`=0
  - `req_ready` and all `ram_*` outputs are 0 in the cycle following reset
- Read latency:
  - grant in cycle N
  - RAM data is captured in cycle N+1
  - `rsp_valid` is high from cycle N+2
- Throughput: 1 write per cycle; 1 read per 2 cycles.
- `req_ready` and the `ram_*` outputs are combinational from `req_valid`, the state and the RR pointer. There is no combinational path from `rsp_ready` except the eligibility check.
- Reset during `RD_CAPTURE` drops the in-flight read; no response is produced.
- Requester holding `req_valid` without a grant must keep its command stable (standard valid/ready rule).
- A read and a write to the same address from different requesters are serialized in grant order.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins, no RR pointer.
  - Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

## Structure
- Package `ram_arb_pkg`: FSM state enum (`IDLE`, `RD_CAPTURE`) and the command struct {wr, addr, data} parameterized through localparams matching `DEPTH`/`WIDTH` defaults.
- Sub-module `rr_arbiter`:
  - Inputs: request vector, `grant_en`. Output: one-hot grant.
  - Owns the pointer.
  - Compiles to fixed priority under `RAM_ARB_FIXED_PRIO_EN`.
- The top instantiates `rr_arbiter` and contains the FSM, RAM mux and response registers.

## Test plan
- **Write then read:** req0 writes 0xA5 to addr 3, then reads addr 3 -> `rsp_valid[0]` high 2 cycles after the read grant, `rsp_data[0]`=0xA5.
- **Round-robin contention:** req0 and req1 both hold writes for 4 cycles -> grants alternate 0,1,0,1. With `RAM_ARB_FIXED_PRIO_EN`, req0 wins all 4 cycles.
- **Response back-pressure:** req1 reads addr 5 (=0x3C) with `rsp_ready[1]`=0, then issues a second read -> the second read is not granted until `rsp_ready[1]` pulses, and `rsp_data[1]` stays 0x3C.
- **Write during RD_CAPTURE:** req0 read pending in `RD_CAPTURE` while req1 write is valid -> req1 is not ready in that cycle and is granted the next cycle.
- **Reset mid-read:** assert `reset_n`=0 in `RD_CAPTURE` -> no `rsp_valid`, all outputs 0, next grant goes to req0.
- **Address wrap:** with `DEPTH`=4, write then read addr 15 -> correct data, no aliasing to addr 0.
